// File: rtl/bracket_nest_checker_pkg.sv
// Shared types and character constants for the bracket nesting checker.
package bracket_nest_pkg;

  typedef enum logic [1:0] {
    PAREN = 2'd0,
    BRACE = 2'd1,
    BRACK = 2'd2
  } br_kind_e;

  typedef enum logic [1:0] {
    S_CODE = 2'd0,
    S_STR  = 2'd1,
    S_ESC  = 2'd2,
    S_ERR  = 2'd3
  } scan_state_e;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_UNTERM   = 2'd3
  } nest_err_e;

  localparam logic [7:0] CH_LPAREN = 8'h28;
  localparam logic [7:0] CH_RPAREN = 8'h29;
  localparam logic [7:0] CH_LBRACE = 8'h7B;
  localparam logic [7:0] CH_RBRACE = 8'h7D;
  localparam logic [7:0] CH_LBRACK = 8'h5B;
  localparam logic [7:0] CH_RBRACK = 8'h5D;
  localparam logic [7:0] CH_QUOTE  = 8'h22;
  localparam logic [7:0] CH_BSLASH = 8'h5C;

  // Decoded view of one input character.
  typedef struct packed {
    logic     is_open;
    logic     is_close;
    logic     is_quote;
    logic     is_bslash;
    br_kind_e kind;
  } char_class_t;

  // Closers carry the kind of the opener they must match.
  function automatic char_class_t classify(input logic [7:0] c);
    char_class_t r;
    r = '0;
    case (c)
      CH_LPAREN: begin r.is_open  = 1'b1; r.kind = PAREN; end
      CH_LBRACE: begin r.is_open  = 1'b1; r.kind = BRACE; end
      CH_LBRACK: begin r.is_open  = 1'b1; r.kind = BRACK; end
      CH_RPAREN: begin r.is_close = 1'b1; r.kind = PAREN; end
      CH_RBRACE: begin r.is_close = 1'b1; r.kind = BRACE; end
      CH_RBRACK: begin r.is_close = 1'b1; r.kind = BRACK; end
      CH_QUOTE:  r.is_quote  = 1'b1;
      CH_BSLASH: r.is_bslash = 1'b1;
      default:   ;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bracket_nest_checker_if.sv
// Byte-stream input and verdict output of the bracket nesting checker.
interface bracket_nest_checker_if #(
  parameter int DEPTH = 16
) ();
  localparam int DW = $clog2(DEPTH + 1);

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          done_valid;
  logic          done_ready;
  logic          done_ok;
  logic [1:0]    done_err;
  logic [DW-1:0] depth;

  modport master (
    output in_valid, in_data, in_last, done_ready,
    input  in_ready, done_valid, done_ok, done_err, depth
  );

  modport slave (
    input  in_valid, in_data, in_last, done_ready,
    output in_ready, done_valid, done_ok, done_err, depth
  );
endinterface

// File: rtl/bracket_nest_checker_stack.sv
// DEPTH x 2-bit LIFO holding the kinds of currently open brackets.
module bracket_stack
  import bracket_nest_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       clear_i,
  input  br_kind_e                   push_kind_i,
  output br_kind_e                   top_o,
  output logic [$clog2(DEPTH+1)-1:0] depth_o
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  br_kind_e      mem_q [DEPTH];
  logic [DW-1:0] depth_q;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] top_idx;

  assign wr_idx  = AW'(depth_q);
  assign top_idx = AW'(depth_q - DW'(1));
  // Top is only meaningful when depth is non-zero; the caller checks that.
  assign top_o   = mem_q[top_idx];
  assign depth_o = depth_q;

  // Entry storage: written on push, never reset.
  always_ff @(posedge clk) begin
    if (push_i && (depth_q != FULL)) begin
      mem_q[wr_idx] <= push_kind_i;
    end
  end

  // Occupancy counter; clear takes priority over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      depth_q <= '0;
    end else if (clear_i) begin
      depth_q <= '0;
    end else if (push_i && (depth_q != FULL)) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop_i && (depth_q != '0)) begin
      depth_q <= depth_q - DW'(1);
    end
  end

endmodule

// File: rtl/bracket_nest_checker.sv
// Streaming bracket nesting checker: classifies bytes, tracks string
// literals, maintains the bracket stack and registers a per-frame verdict.
module bracket_nest_checker
  import bracket_nest_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  bracket_nest_checker_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  char_class_t   cls;
  scan_state_e   state_q, state_d;
  nest_err_e     err_q, err_d, final_err;
  logic          done_valid_q, done_valid_d;
  logic          done_ok_q, done_ok_d;
  nest_err_e     done_err_q, done_err_d;
  logic          xfer, push, pop, clear;
  br_kind_e      top;
  logic [DW-1:0] stk_depth, depth_post;

  bracket_stack #(.DEPTH(DEPTH)) u_stack (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .pop_i       (pop),
    .clear_i     (clear),
    .push_kind_i (cls.kind),
    .top_o       (top),
    .depth_o     (stk_depth)
  );

  // A pending verdict blocks input, giving at least one bubble per frame.
  assign xfer          = bus.in_valid && !done_valid_q;
  assign bus.in_ready  = !done_valid_q;
  assign bus.done_valid = done_valid_q;
  assign bus.done_ok   = done_ok_q;
  assign bus.done_err  = done_err_q;
  assign bus.depth     = stk_depth;

  // Scanner next state, stack commands and end-of-frame verdict.
  always_comb begin
    cls          = classify(bus.in_data);
    state_d      = state_q;
    err_d        = err_q;
    final_err    = err_q;
    push         = 1'b0;
    pop          = 1'b0;
    clear        = 1'b0;
    depth_post   = stk_depth;
    done_valid_d = done_valid_q;
    done_ok_d    = done_ok_q;
    done_err_d   = done_err_q;

    if (done_valid_q && bus.done_ready) begin
      done_valid_d = 1'b0;
      done_ok_d    = 1'b0;
      done_err_d   = ERR_OK;
    end

    if (xfer) begin
      case (state_q)
        S_CODE: begin
          if (cls.is_quote) begin
            state_d = S_STR;
          end else if (cls.is_open) begin
            if (stk_depth == FULL) begin
              err_d   = ERR_OVERFLOW;
              state_d = S_ERR;
            end else begin
              push       = 1'b1;
              depth_post = stk_depth + DW'(1);
            end
          end else if (cls.is_close) begin
            if ((stk_depth == '0) || (top != cls.kind)) begin
              err_d   = ERR_MISMATCH;
              state_d = S_ERR;
            end else begin
              pop        = 1'b1;
              depth_post = stk_depth - DW'(1);
            end
          end
        end
        S_STR: begin
          if (cls.is_quote) begin
            state_d = S_CODE;
          end else if (cls.is_bslash) begin
            state_d = S_ESC;
          end
        end
        S_ESC:   state_d = S_STR;
        default: ;
      endcase

      // The last byte is processed first; an earlier error always wins.
      if (bus.in_last) begin
        final_err = err_d;
        if ((err_d == ERR_OK) &&
            ((depth_post != '0) || (state_d == S_STR) || (state_d == S_ESC))) begin
          final_err = ERR_UNTERM;
        end
        done_valid_d = 1'b1;
        done_ok_d    = (final_err == ERR_OK);
        done_err_d   = final_err;
        state_d      = S_CODE;
        err_d        = ERR_OK;
        clear        = 1'b1;
      end
    end
  end

  // Scanner state, latched error and verdict registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_CODE;
      err_q        <= ERR_OK;
      done_valid_q <= 1'b0;
      done_ok_q    <= 1'b0;
      done_err_q   <= ERR_OK;
    end else begin
      state_q      <= state_d;
      err_q        <= err_d;
      done_valid_q <= done_valid_d;
      done_ok_q    <= done_ok_d;
      done_err_q   <= done_err_d;
    end
  end

endmodule
